// File: rtl/time_slot_calculation_pkg.sv
// Shared definitions for the time-slot calculation block: FSM encoding,
// slot-length shift constants and default widths.
package time_slot_calculation_pkg;

  // Slot length is 2^(BASE_SHIFT + sel) ns; sel saturates at MAX_SEL.
  localparam int BASE_SHIFT = 10;
  localparam int MAX_SEL    = 11;

  localparam int DEF_TIME_W = 48;
  localparam int DEF_SLOT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } slot_state_t;

  // Saturate the raw slot-length select to the largest supported value.
  function automatic logic [3:0] clamp_sel(input logic [3:0] sel);
    return (sel > 4'(MAX_SEL)) ? 4'(MAX_SEL) : sel;
  endfunction

endpackage

// File: rtl/time_slot_calculation_boundary_detect.sv
// slot_boundary_detect: watches the slot-length bit of the synchronised time
// and strobes for one cycle whenever it toggles. A boundary is only honoured
// once one cycle of history exists after reset.
// Optional macro TIME_SLOT_JUMP_DETECT_EN adds a time-discontinuity flag.
module slot_boundary_detect
  import time_slot_calculation_pkg::*;
#(
  parameter int TIME_W = DEF_TIME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] syn_clk,
  input  logic [3:0]        sel,
`ifdef TIME_SLOT_JUMP_DETECT_EN
  output logic              time_jump,
`endif
  output logic              boundary
);

  localparam int POS_W = $clog2(TIME_W);

  logic [POS_W-1:0] bit_pos;
  logic             cur_bit;
  logic             prev_bit;
  logic             hist_valid;

  assign bit_pos  = POS_W'(BASE_SHIFT) + POS_W'(sel);
  assign cur_bit  = syn_clk[bit_pos];
  assign boundary = hist_valid & (cur_bit ^ prev_bit);

  // Remember last cycle's slot bit and note that history is now available.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_bit   <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      prev_bit   <= cur_bit;
      hist_valid <= 1'b1;
    end
  end

`ifdef TIME_SLOT_JUMP_DETECT_EN
  logic [TIME_W-1:0] prev_time;
  logic [TIME_W-1:0] step;
  logic [TIME_W-1:0] slot_len;

  assign step      = syn_clk - prev_time;
  assign slot_len  = TIME_W'(1) << bit_pos;
  assign time_jump = hist_valid & ((syn_clk < prev_time) | (step > slot_len));

  // Keep the previous time sample to measure the per-cycle step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_time <= '0;
    else     prev_time <= syn_clk;
  end
`endif

endmodule

// File: rtl/time_slot_calculation.sv
// time_slot_calculation: derives the current gate-control slot index from the
// global synchronised time. IDLE/SYNC/RUN FSM with a registered index, a
// one-cycle switch pulse and a valid flag.
// Optional macro TIME_SLOT_JUMP_DETECT_EN adds o_time_jump and forces a
// resync when the time steps backwards or forward by more than one slot.
module time_slot_calculation
  import time_slot_calculation_pkg::*;
#(
  parameter int TIME_W = DEF_TIME_W,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [TIME_W-1:0] iv_syn_clk,
  input  logic              i_enable,
  input  logic [3:0]        iv_slot_len_sel,
  input  logic [SLOT_W-1:0] iv_slot_period,
`ifdef TIME_SLOT_JUMP_DETECT_EN
  output logic              o_time_jump,
`endif
  output logic [SLOT_W-1:0] ov_time_slot,
  output logic              o_time_slot_switch,
  output logic              o_slot_valid
);

  slot_state_t       state, state_next;
  logic [3:0]        eff_sel, sel_q;
  logic [SLOT_W-1:0] eff_period, period_q, last_idx;
  logic [SLOT_W-1:0] slot_idx, idx_next;
  logic              switch_q, switch_next;
  logic              cfg_change;
  logic              boundary;

  assign eff_sel    = clamp_sel(iv_slot_len_sel);
  assign eff_period = (iv_slot_period == '0) ? SLOT_W'(1) : iv_slot_period;
  assign last_idx   = eff_period - SLOT_W'(1);
  assign cfg_change = (eff_sel != sel_q) || (eff_period != period_q);

`ifdef TIME_SLOT_JUMP_DETECT_EN
  logic time_jump, jump_q, jump_next;

  slot_boundary_detect #(.TIME_W(TIME_W)) u_detect (
    .clk       (i_clk),
    .rst       (i_rst),
    .syn_clk   (iv_syn_clk),
    .sel       (eff_sel),
    .time_jump (time_jump),
    .boundary  (boundary)
  );

  assign o_time_jump = jump_q;
`else
  slot_boundary_detect #(.TIME_W(TIME_W)) u_detect (
    .clk      (i_clk),
    .rst      (i_rst),
    .syn_clk  (iv_syn_clk),
    .sel      (eff_sel),
    .boundary (boundary)
  );
`endif

  assign ov_time_slot       = slot_idx;
  assign o_time_slot_switch = switch_q;
  assign o_slot_valid       = (state == ST_RUN);

  // Shadow the effective configuration so a change can be seen one cycle on.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_q    <= '0;
      period_q <= '0;
    end else begin
      sel_q    <= eff_sel;
      period_q <= eff_period;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, next index and pulse requests; config change beats a boundary.
  always_comb begin
    state_next  = state;
    idx_next    = slot_idx;
    switch_next = 1'b0;
`ifdef TIME_SLOT_JUMP_DETECT_EN
    jump_next   = 1'b0;
`endif
    if (!i_enable) begin
      state_next = ST_IDLE;
      idx_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_SYNC;
          idx_next   = '0;
        end
        ST_SYNC: begin
          idx_next = '0;
          if (boundary && !cfg_change) begin
            state_next  = ST_RUN;
            switch_next = 1'b1;
          end
        end
        ST_RUN: begin
          if (cfg_change) begin
            state_next = ST_SYNC;
            idx_next   = '0;
          end
`ifdef TIME_SLOT_JUMP_DETECT_EN
          else if (time_jump) begin
            state_next = ST_SYNC;
            idx_next   = '0;
            jump_next  = 1'b1;
          end
`endif
          else if (boundary) begin
            switch_next = 1'b1;
            idx_next    = (slot_idx >= last_idx) ? '0 : slot_idx + SLOT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Registered slot index and one-cycle pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_idx <= '0;
      switch_q <= 1'b0;
`ifdef TIME_SLOT_JUMP_DETECT_EN
      jump_q   <= 1'b0;
`endif
    end else begin
      slot_idx <= idx_next;
      switch_q <= switch_next;
`ifdef TIME_SLOT_JUMP_DETECT_EN
      jump_q   <= jump_next;
`endif
    end
  end

endmodule

// File: tb/tb_time_slot_calculation.sv
// Directed self-checking bench for time_slot_calculation: slot sequencing,
// period/sel saturation, config-change resync, async reset and time jumps.
module tb_time_slot_calculation;

  localparam int TIME_W = 48;
  localparam int SLOT_W = 10;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [TIME_W-1:0] iv_syn_clk;
  logic              i_enable;
  logic [3:0]        iv_slot_len_sel;
  logic [SLOT_W-1:0] iv_slot_period;
  logic [SLOT_W-1:0] ov_time_slot;
  logic              o_time_slot_switch;
  logic              o_slot_valid;
`ifdef TIME_SLOT_JUMP_DETECT_EN
  logic              o_time_jump;
`endif

  int checks   = 0;
  int failures = 0;
  int n;

  time_slot_calculation #(.TIME_W(TIME_W), .SLOT_W(SLOT_W)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .iv_syn_clk         (iv_syn_clk),
    .i_enable           (i_enable),
    .iv_slot_len_sel    (iv_slot_len_sel),
    .iv_slot_period     (iv_slot_period),
`ifdef TIME_SLOT_JUMP_DETECT_EN
    .o_time_jump        (o_time_jump),
`endif
    .ov_time_slot       (ov_time_slot),
    .o_time_slot_switch (o_time_slot_switch),
    .o_slot_valid       (o_slot_valid)
  );

  // 125 MHz clock.
  always #4 i_clk = ~i_clk;

  // One clock: sample outputs just after the edge, then advance time by 8 ns.
  task automatic tick();
    @(posedge i_clk);
    #1;
    iv_syn_clk = iv_syn_clk + TIME_W'(8);
  endtask

  task automatic apply_stimulus(input logic en, input logic [3:0] sel,
                                input logic [SLOT_W-1:0] period);
    i_enable        = en;
    iv_slot_len_sel = sel;
    iv_slot_period  = period;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input int slot, input bit sw,
                               input bit valid);
    check_output({tag, "_slot"},   64'(ov_time_slot),       64'(slot));
    check_output({tag, "_switch"}, 64'(o_time_slot_switch), 64'(sw));
    check_output({tag, "_valid"},  64'(o_slot_valid),       64'(valid));
  endtask

  // Tick until a switch pulse is seen or the budget runs out.
  task automatic wait_switch(input int max_ticks, output int count);
    count = 0;
    do begin
      tick();
      count++;
    end while (o_time_slot_switch !== 1'b1 && count < max_ticks);
  endtask

  initial begin
    int exp_seq [4] = '{1, 2, 3, 0};

    // Reset state.
    i_rst      = 1'b1;
    iv_syn_clk = '0;
    apply_stimulus(1'b0, 4'd0, SLOT_W'(4));
    repeat (3) @(posedge i_clk);
    #1;
    check_outputs("reset", 0, 1'b0, 1'b0);

    // sel=0, period=4, time from 0 at 8 ns/cycle.
    i_rst = 1'b0;
    apply_stimulus(1'b1, 4'd0, SLOT_W'(4));
    tick();
    check_outputs("first_cycle", 0, 1'b0, 1'b0);
    wait_switch(200, n);
    check_output("first_switch_ticks", 64'(n), 64'd128);
    check_outputs("slot0", 0, 1'b1, 1'b1);
    tick();
    check_outputs("slot0_hold", 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_switch(200, n);
      check_output("slot_spacing", 64'(n), 64'd127);
      check_outputs("slot_seq", exp_seq[i], 1'b1, 1'b1);
      tick();
      check_output("slot_pulse_width", 64'(o_time_slot_switch), 64'd0);
    end

    // Period 4 -> 8 forces resync, then walk to index 5.
    apply_stimulus(1'b1, 4'd0, SLOT_W'(8));
    tick();
    check_outputs("p8_resync", 0, 1'b0, 1'b0);
    wait_switch(200, n);
    check_output("p8_entry_ticks", 64'(n), 64'd126);
    check_outputs("p8_entry", 0, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      wait_switch(200, n);
      check_output("p8_spacing", 64'(n), 64'd128);
      check_outputs("p8_step", k, 1'b1, 1'b1);
    end

    // Period 8 -> 3 while index is 5.
    apply_stimulus(1'b1, 4'd0, SLOT_W'(3));
    tick();
    check_outputs("period_drop", 0, 1'b0, 1'b0);
    wait_switch(200, n);
    check_output("period_drop_ticks", 64'(n), 64'd127);
    check_outputs("period_drop_reentry", 0, 1'b1, 1'b1);

    // Period 0 behaves as 1: index stays 0, pulse every boundary.
    apply_stimulus(1'b1, 4'd0, SLOT_W'(0));
    tick();
    check_outputs("p0_resync", 0, 1'b0, 1'b0);
    wait_switch(200, n);
    check_output("p0_entry_ticks", 64'(n), 64'd127);
    check_outputs("p0_entry", 0, 1'b1, 1'b1);
    wait_switch(200, n);
    check_output("p0_wrap_ticks", 64'(n), 64'd128);
    check_outputs("p0_wrap", 0, 1'b1, 1'b1);

    // sel=15 saturates to 11: boundaries on bit 21 only.
    apply_stimulus(1'b1, 4'd15, SLOT_W'(0));
    tick();
    check_outputs("sel15_resync", 0, 1'b0, 1'b0);
    iv_syn_clk = TIME_W'(2097152 - 40);
    wait_switch(50, n);
    check_output("sel15_entry_ticks", 64'(n), 64'd6);
    check_outputs("sel15_entry", 0, 1'b1, 1'b1);
    apply_stimulus(1'b1, 4'd11, SLOT_W'(0));
    tick();
    check_outputs("sel15_eq_11", 0, 1'b0, 1'b1);
    wait_switch(200, n);
    check_output("sel11_no_bit10_ticks", 64'(n), 64'd200);
    check_outputs("sel11_no_bit10", 0, 1'b0, 1'b1);

    // Reset mid-RUN at index 2.
    apply_stimulus(1'b1, 4'd0, SLOT_W'(4));
    tick();
    check_outputs("sel0_resync", 0, 1'b0, 1'b0);
    wait_switch(300, n);
    check_outputs("rst_idx0", 0, 1'b1, 1'b1);
    wait_switch(200, n);
    check_outputs("rst_idx1", 1, 1'b1, 1'b1);
    wait_switch(200, n);
    check_output("rst_idx2_ticks", 64'(n), 64'd128);
    check_outputs("rst_idx2", 2, 1'b1, 1'b1);
    #1;
    i_rst = 1'b1;
    #1;
    check_outputs("async_reset", 0, 1'b0, 1'b0);
    tick();
    i_rst = 1'b0;
    tick();
    check_outputs("post_reset_sync", 0, 1'b0, 1'b0);
    wait_switch(300, n);
    check_outputs("post_reset_run", 0, 1'b1, 1'b1);

    // Time steps back 5000 ns in RUN (bit 10 toggles).
    iv_syn_clk = iv_syn_clk - TIME_W'(5000);
    tick();
`ifdef TIME_SLOT_JUMP_DETECT_EN
    check_output("jump_pulse", 64'(o_time_jump), 64'd1);
    check_outputs("jump_sync", 0, 1'b0, 1'b0);
    tick();
    check_output("jump_pulse_end", 64'(o_time_jump), 64'd0);
    check_output("jump_still_sync", 64'(o_slot_valid), 64'd0);
`else
    check_outputs("jump_boundary", 1, 1'b1, 1'b1);
    tick();
    check_outputs("jump_after", 1, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_slot_calculation.md
TIME_SLOT_CALCULATION -- requirements
Module: time_slot_calculation

Interface
REQ-001 Parameter TIME_W, default 48: width of global synchronised time, in ns.
REQ-002 Parameter SLOT_W, default 10: width of time-slot index.
REQ-003 i_clk  input  1  125 MHz clock; single clock domain.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 iv_syn_clk  input  TIME_W  global synchronised time in ns; advances by 8 per cycle nominally.
REQ-006 i_enable  input  1  slot calculation enable.
REQ-007 iv_slot_len_sel  input  4  slot length select; slot length = 2^(10+sel) ns.
REQ-008 iv_slot_period  input  SLOT_W  number of slots per gate-control cycle.
REQ-009 ov_time_slot  output  SLOT_W  current slot index; feeds gate-list read address.
REQ-010 o_time_slot_switch  output  1  one-cycle pulse when ov_time_slot takes a new value.
REQ-011 o_slot_valid  output  1  high while ov_time_slot is aligned and valid (RUN).

Function
REQ-012 Effective sel SHALL be min(iv_slot_len_sel, 11); effective period SHALL be max(iv_slot_period, 1).
REQ-013 Boundary SHALL be detected when bit (10+sel) of iv_syn_clk differs from its registered value of the previous cycle.
REQ-014 FSM states: IDLE, SYNC, RUN.
REQ-015 IDLE -> SYNC when i_enable=1; any state -> IDLE when i_enable=0.
REQ-016 SYNC -> RUN on first boundary; on that cycle the index loads 0.
REQ-017 In RUN, each boundary increments the index; index == period-1 wraps to 0.
REQ-018 Outputs SHALL be registered: ov_time_slot and o_time_slot_switch update one cycle after the boundary cycle.
REQ-019 o_time_slot_switch SHALL pulse for exactly one cycle on SYNC->RUN entry and on every RUN increment/wrap; never in IDLE/SYNC.
REQ-020 A change of effective sel or period (registered compare) while in RUN SHALL force SYNC, with ov_time_slot = 0 and o_slot_valid = 0 until the next boundary.
REQ-021 Config change and boundary in the same cycle: the config change wins; no switch pulse.
REQ-022 In IDLE and SYNC, ov_time_slot SHALL be 0 and o_slot_valid SHALL be 0.
REQ-023 If the index exceeds period-1 because of a period change, it SHALL reset to 0 through SYNC; it SHALL never be output as an out-of-range index.

Reset
REQ-024 On i_rst: state = IDLE, ov_time_slot = 0, o_time_slot_switch = 0, o_slot_valid = 0, previous-bit and configuration shadow registers = 0.
REQ-025 Reset asserted mid-RUN SHALL clear outputs immediately (asynchronously).
REQ-026 After reset release, a boundary needs one full cycle of history before it is honoured; no switch pulse on the first cycle.

Configuration
REQ-027 Macro TIME_SLOT_JUMP_DETECT_EN: when defined, a time step (current - previous iv_syn_clk) that is negative or > 2^(10+sel) ns in RUN SHALL force SYNC and pulse output o_time_jump (1 bit, reset 0) for one cycle.
REQ-028 Without the macro, o_time_jump SHALL not exist and time discontinuities SHALL be treated only by the boundary rule (REQ-013).

Structure
REQ-029 The shared package SHALL hold the FSM state encoding, the base shift constant 10, the maximum sel 11, and the default widths.
REQ-030 A sub-module, slot_boundary_detect (bit select, previous-bit register, optional jump check), SHALL produce a one-cycle boundary strobe; the FSM and index counter live in the top module.

Verification
REQ-031 sel=0, period=4, enable, time +8/cycle from 0: first switch after 1024 ns boundary; slots 0,1,2,3,0 with 128-cycle spacing.
REQ-032 iv_slot_period=0: index stays 0 with a switch pulse every boundary; iv_slot_len_sel=15 behaves exactly as sel=11 (2,097,152 ns slots).
REQ-033 Period changed 8->3 while index=5: o_slot_valid drops next cycle, index 0, no pulse; next boundary gives index 0 with a pulse.
REQ-034 i_rst asserted while index=2 in RUN: outputs read 0 asynchronously; after release + enable, the bench expects SYNC then index 0.
REQ-035 With TIME_SLOT_JUMP_DETECT_EN, sel=0: time steps back 5000 ns -> o_time_jump pulses once, state SYNC, o_slot_valid=0; without the macro, index continues by the boundary rule.
